// File: rtl/cla_pkg.sv
// Shared KGP types and helpers for the pipelined carry-lookahead adder.
// Symbols: K=00, P=01 (10 also reads as P), G=11.
package cla_pkg;

  typedef logic [1:0] kgp_t;

  localparam kgp_t KGP_K = 2'b00;
  localparam kgp_t KGP_P = 2'b01;
  localparam kgp_t KGP_G = 2'b11;

  function automatic kgp_t kgp_encode(
    input logic a_bit,
    input logic b_bit
  );
    if (a_bit & b_bit)
      return KGP_G;
    else if (~a_bit & ~b_bit)
      return KGP_K;
    else
      return KGP_P;
  endfunction

  // hi is the more significant span; K/G in hi decides, P defers to lo.
  function automatic kgp_t kgp_combine(
    input kgp_t lo,
    input kgp_t hi
  );
    return (hi[1] == hi[0]) ? hi : lo;
  endfunction

endpackage

// File: rtl/kgp_prefix_cell.sv
// One Kogge-Stone prefix node: combinational KGP combine.
// lo is the less significant span, hi the more significant.
module kgp_prefix_cell
  import cla_pkg::*;
(
  input  kgp_t lo_i,
  input  kgp_t hi_i,
  output kgp_t grp_o
);

  assign grp_o = kgp_combine(lo_i, hi_i);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined KGP Kogge-Stone adder with valid/ready stream handshake.
// Optional CLA_PIPE_OVF_EN adds a registered signed-overflow output.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef CLA_PIPE_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int LEVELS = $clog2(WIDTH);

  // index 0 is the encode stage, index l is prefix level l
  kgp_t             grp_q [LEVELS+1][WIDTH];
  logic [WIDTH-1:0] p_q   [LEVELS+1];
  logic [LEVELS:0]  cin_q;
  logic [LEVELS:0]  v_q;

  kgp_t             enc_d [WIDTH];
  kgp_t             lvl_d [LEVELS][WIDTH];
  logic [WIDTH-1:0] c_d;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             en;

  assign en        = ~out_valid_q | out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Encode operand bits; bit 0 absorbs the carry-in symbol.
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      enc_d[i] = kgp_encode(a[i], b[i]);
    enc_d[0] = kgp_combine(cin ? KGP_G : KGP_K,
                           kgp_encode(a[0], b[0]));
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    for (genvar i = 0; i < WIDTH; i++) begin : g_pos
      if (i >= (1 << (l - 1))) begin : g_cell
        kgp_prefix_cell u_cell (
          .lo_i  (grp_q[l-1][i-(1<<(l-1))]),
          .hi_i  (grp_q[l-1][i]),
          .grp_o (lvl_d[l-1][i])
        );
      end else begin : g_pass
        assign lvl_d[l-1][i] = grp_q[l-1][i];
      end
    end
  end

  // Carry into each bit from the resolved group symbols.
  always_comb begin
    c_d    = '0;
    c_d[0] = cin_q[LEVELS];
    for (int i = 1; i < WIDTH; i++)
      c_d[i] = (grp_q[LEVELS][i-1] == KGP_G);
  end

  assign sum_d  = p_q[LEVELS] ^ c_d;
  assign cout_d = (grp_q[LEVELS][WIDTH-1] == KGP_G);

  // Valid bits advance on the global enable; data loads only with valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else if (en) begin
      v_q[0] <= in_valid;
      if (in_valid) begin
        grp_q[0] <= enc_d;
        p_q[0]   <= a ^ b;
        cin_q[0] <= cin;
      end
      for (int l = 1; l <= LEVELS; l++) begin
        v_q[l] <= v_q[l-1];
        if (v_q[l-1]) begin
          grp_q[l] <= lvl_d[l-1];
          p_q[l]   <= p_q[l-1];
          cin_q[l] <= cin_q[l-1];
        end
      end
      out_valid_q <= v_q[LEVELS];
      if (v_q[LEVELS]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end
  end

`ifdef CLA_PIPE_OVF_EN
  logic ovf_q;

  assign ovf = ovf_q;

  // Signed overflow: carry into MSB differs from carry out.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (en && v_q[LEVELS])
      ovf_q <= c_d[WIDTH-1] ^ cout_d;
  end
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at WIDTH=16.
// Define CLA_PIPE_OVF_EN to also exercise the overflow output.
module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef CLA_PIPE_OVF_EN
  logic         ovf;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef CLA_PIPE_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x,
                                       input logic [W-1:0] y,
                                       input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  task automatic drive(input logic [W-1:0] x,
                       input logic [W-1:0] y,
                       input logic c);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = c;
  endtask

  // Single beat: returns cycles from presentation to out_valid.
  task automatic run_one(input  logic [W-1:0] x,
                         input  logic [W-1:0] y,
                         input  logic c,
                         output int lat,
                         output logic [W-1:0] s,
                         output logic co);
    out_ready = 1'b1;
    drive(x, y, c);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    s  = sum;
    co = cout;
  endtask

  logic [W:0]   exp_q [$];
  logic [W:0]   ev;
  logic [W-1:0] ra, rb, rs, hs;
  logic         rc, rco, hc;
  int           lat, n_in, n_out, first_c, last_c, seen;
  logic [W-1:0] da [4];
  logic [W-1:0] db [4];
  logic         dc [4];

  initial begin
    da = '{16'h1234, 16'h8000, 16'hAAAA, 16'h0000};
    db = '{16'h4321, 16'h8000, 16'h5555, 16'h0000};
    dc = '{1'b0, 1'b0, 1'b1, 1'b1};

    // reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
`ifdef CLA_PIPE_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // carry through all bits, latency
    run_one(16'hFFFF, 16'h0001, 1'b0, lat, rs, rco);
    chk("lat_ffff_1", lat, 32'd6);
    chk("sum_ffff_1", {16'd0, rs}, 32'h0000);
    chk("cout_ffff_1", {31'd0, rco}, 32'd1);

    run_one(16'hFFFF, 16'h0000, 1'b1, lat, rs, rco);
    chk("lat_ffff_cin", lat, 32'd6);
    chk("sum_ffff_cin", {16'd0, rs}, 32'h0000);
    chk("cout_ffff_cin", {31'd0, rco}, 32'd1);

    run_one(16'h1234, 16'h4321, 1'b0, lat, rs, rco);
    chk("sum_1234_4321", {16'd0, rs}, 32'h5555);
    chk("cout_1234_4321", {31'd0, rco}, 32'd0);

`ifdef CLA_PIPE_OVF_EN
    run_one(16'h7FFF, 16'h0001, 1'b0, lat, rs, rco);
    chk("sum_7fff_1", {16'd0, rs}, 32'h8000);
    chk("ovf_7fff_1", {31'd0, ovf}, 32'd1);
    run_one(16'h8000, 16'hFFFF, 1'b0, lat, rs, rco);
    chk("sum_8000_ffff", {16'd0, rs}, 32'h7FFF);
    chk("cout_8000_ffff", {31'd0, rco}, 32'd1);
    chk("ovf_8000_ffff", {31'd0, ovf}, 32'd1);
    run_one(16'h1234, 16'h4321, 1'b0, lat, rs, rco);
    chk("ovf_1234_4321", {31'd0, ovf}, 32'd0);
`endif

    // back-to-back stream: 4 directed then 100 random
    step();
    exp_q.delete();
    out_ready = 1'b1;
    n_in = 0;
    n_out = 0;
    first_c = -1;
    last_c = -1;
    for (int cyc = 0; cyc < 400 && n_out < 104; cyc++) begin
      if (n_in < 104 && in_ready) begin
        if (n_in < 4) begin
          ra = da[n_in];
          rb = db[n_in];
          rc = dc[n_in];
        end else begin
          ra = W'($urandom);
          rb = W'($urandom);
          rc = 1'($urandom);
        end
        drive(ra, rb, rc);
        exp_q.push_back(model(ra, rb, rc));
        n_in++;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (out_valid) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        ev = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        chk("stream", {15'd0, cout, sum}, {15'd0, ev});
        n_out++;
      end
    end
    in_valid = 1'b0;
    chk("stream_count", n_out, 32'd104);
    chk("stream_rate", last_c - first_c + 1, 32'd104);

    // fill with out_ready low, then stall
    step();
    exp_q.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      drive(ra, rb, rc);
      if (in_ready) exp_q.push_back(model(ra, rb, rc));
      step();
    end
    chk("stall_accepted", exp_q.size(), 32'd6);
    hs = sum;
    hc = cout;
    ev = (exp_q.size() != 0) ? exp_q[0] : '1;
    chk("stall_head", {15'd0, hc, hs}, {15'd0, ev});
    for (int k = 0; k < 5; k++) begin
      ra = W'($urandom);
      drive(ra, ~ra, 1'b1);
      step();
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold", {15'd0, cout, sum}, {15'd0, hc, hs});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_out = 0;
    for (int k = 0; k < 30 && exp_q.size() != 0; k++) begin
      if (out_valid) begin
        ev = exp_q.pop_front();
        chk("drain", {15'd0, cout, sum}, {15'd0, ev});
        n_out++;
      end
      step();
    end
    chk("drain_count", n_out, 32'd6);
    step();
    chk("drain_empty", {31'd0, out_valid}, 32'd0);

    // reset with three beats in flight
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(W'($urandom), W'($urandom), 1'b0);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid) seen++;
    end
    chk("midrst_stale", seen, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
